// File: rtl/atm_ledger_arbiter.sv
// Purpose : round-robin arbiter sharing one account balance between N_REQ ATM
//           sessions; executes one atomic check/withdraw/deposit at a time.
// Latency : req sampled in cycle 0 -> gnt in cycle 1 -> done in cycle 3; at most
//           one grant every 4 cycles.
// Backpressure: sessions hold req high until done; losers stay pending and are
//           served in round-robin order, so no session waits more than N_REQ
//           transactions.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous reset, active-low
//   req      per-session request, held high until done
//   req_op   op of session i at [2i+1:2i]: 01 check, 10 withdraw, 11 deposit, 00 illegal
//   req_amt  amount of session i at [BAL_W*i +: BAL_W]
//   gnt      one-hot grant, zero when idle
//   busy     transaction in flight (GRANT/EXEC/RESP)
//   done     one-cycle completion pulse
//   ok       with done: 1 committed, 0 rejected (held until the next done)
//   rsp_bal  with done: balance after the transaction (held until the next done)
//   balance  current ledger balance
//   tx_cnt   committed withdraw+deposit count, wraps 255->0
module atm_ledger_arbiter #(
   parameter int               N_REQ    = 2,
   parameter int               BAL_W    = 8,
   parameter logic [BAL_W-1:0] INIT_BAL = BAL_W'(100)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [2*N_REQ-1:0]      req_op,
   input  logic [BAL_W*N_REQ-1:0]  req_amt,
   output logic [N_REQ-1:0]        gnt,
   output logic                    busy,
   output logic                    done,
   output logic                    ok,
   output logic [BAL_W-1:0]        rsp_bal,
   output logic [BAL_W-1:0]        balance,
   output logic [7:0]              tx_cnt
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_EXEC  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t             state, state_nx;
   logic [N_REQ-1:0]   gnt_nx;
   logic               busy_nx, done_nx, ok_nx;
   logic [BAL_W-1:0]   rsp_bal_nx, balance_nx;
   logic [7:0]         tx_cnt_nx;
   logic [IDX_W-1:0]   rr_ptr, rr_ptr_nx;
   logic [IDX_W-1:0]   sel_idx, sel_idx_nx;
   logic [1:0]         lat_op, lat_op_nx;
   logic [BAL_W-1:0]   lat_amt, lat_amt_nx;

   // Round-robin pick: first set req at or after rr_ptr, wrapping.
   logic               pick_vld;
   logic [IDX_W-1:0]   pick_idx;

   always_comb begin
      int cand;
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = 0;
      // Walk from the farthest candidate back to rr_ptr so the nearest wins.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = (int'(rr_ptr) + k) % N_REQ;
         if (req[cand]) begin
            pick_vld = 1'b1;
            pick_idx = IDX_W'(cand);
         end
      end
   end

   // One extra bit so deposit overflow is visible as the carry.
   logic [BAL_W:0] dep_sum;
   assign dep_sum = {1'b0, balance} + {1'b0, lat_amt};

   always_comb begin
      state_nx   = state;
      gnt_nx     = gnt;
      busy_nx    = busy;
      done_nx    = done;
      ok_nx      = ok;
      rsp_bal_nx = rsp_bal;
      balance_nx = balance;
      tx_cnt_nx  = tx_cnt;
      rr_ptr_nx  = rr_ptr;
      sel_idx_nx = sel_idx;
      lat_op_nx  = lat_op;
      lat_amt_nx = lat_amt;

      case (state)
         S_IDLE: begin
            if (pick_vld) begin
               gnt_nx           = '0;
               gnt_nx[pick_idx] = 1'b1;
               busy_nx          = 1'b1;
               sel_idx_nx       = pick_idx;
               lat_op_nx        = req_op[2*pick_idx +: 2];
               lat_amt_nx       = req_amt[BAL_W*pick_idx +: BAL_W];
               state_nx         = S_GRANT;
            end
         end

         S_GRANT: begin
            // A session that withdraws before execution forfeits its turn
            // without advancing the pointer.
            if (!req[sel_idx]) begin
               gnt_nx   = '0;
               busy_nx  = 1'b0;
               state_nx = S_IDLE;
            end else begin
               state_nx = S_EXEC;
            end
         end

         S_EXEC: begin
            done_nx    = 1'b1;
            ok_nx      = 1'b0;
            rsp_bal_nx = balance;
            case (lat_op)
               2'b01: ok_nx = 1'b1;
               2'b10: begin
                  if (lat_amt <= balance) begin
                     ok_nx      = 1'b1;
                     balance_nx = balance - lat_amt;
                     rsp_bal_nx = balance - lat_amt;
                     tx_cnt_nx  = tx_cnt + 8'd1;
                  end
               end
               2'b11: begin
                  if (!dep_sum[BAL_W]) begin
                     ok_nx      = 1'b1;
                     balance_nx = dep_sum[BAL_W-1:0];
                     rsp_bal_nx = dep_sum[BAL_W-1:0];
                     tx_cnt_nx  = tx_cnt + 8'd1;
                  end
               end
               default: ok_nx = 1'b0;
            endcase
            state_nx = S_RESP;
         end

         S_RESP: begin
            done_nx  = 1'b0;
            gnt_nx   = '0;
            busy_nx  = 1'b0;
            if (sel_idx == IDX_W'(N_REQ - 1))
               rr_ptr_nx = '0;
            else
               rr_ptr_nx = sel_idx + 1'b1;
            state_nx = S_IDLE;
         end

         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= S_IDLE;
         gnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ok      <= 1'b0;
         rsp_bal <= '0;
         balance <= INIT_BAL;
         tx_cnt  <= 8'd0;
         rr_ptr  <= '0;
         sel_idx <= '0;
         lat_op  <= 2'b00;
         lat_amt <= '0;
      end else begin
         state   <= state_nx;
         gnt     <= gnt_nx;
         busy    <= busy_nx;
         done    <= done_nx;
         ok      <= ok_nx;
         rsp_bal <= rsp_bal_nx;
         balance <= balance_nx;
         tx_cnt  <= tx_cnt_nx;
         rr_ptr  <= rr_ptr_nx;
         sel_idx <= sel_idx_nx;
         lat_op  <= lat_op_nx;
         lat_amt <= lat_amt_nx;
      end
   end

endmodule
